// File: rtl/mst_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mst_fifo_pkg : state encoding and constants for the FT600 scheduler |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mst_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RX_OE  = 3'd1,
    ST_RX_RD  = 3'd2,
    ST_RX_END = 3'd3,
    ST_TX_DRV = 3'd4,
    ST_TX_WR  = 3'd5,
    ST_TX_END = 3'd6
  } state_e;

  localparam logic DIR_RX = 1'b0;
  localparam logic DIR_TX = 1'b1;

  // Bus turnaround length in cycles, and the width of its counter.
  localparam int TA_CYC = 1;
  localparam int TA_W   = 4;

endpackage
`default_nettype wire

// File: rtl/mst_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mst_rr_pick : two-requester round-robin picker with last-grant reg  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mst_rr_pick (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req_rx_i,
  input  logic req_tx_i,
  output logic gnt_rx_o,
  output logic gnt_tx_o,
  output logic last_o
);
  import mst_fifo_pkg::*;

  logic last_q;
  logic last_d;

  // On a tie the direction that was not granted last wins.
  always_comb begin
    gnt_rx_o = 1'b0;
    gnt_tx_o = 1'b0;
    last_d   = last_q;
    if (en_i) begin
      if (req_rx_i && (!req_tx_i || (last_q == DIR_TX))) begin
        gnt_rx_o = 1'b1;
        last_d   = DIR_RX;
      end else if (req_tx_i) begin
        gnt_tx_o = 1'b1;
        last_d   = DIR_TX;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= DIR_TX;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_o = last_q;

endmodule
`default_nettype wire

// File: rtl/mst_bus_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mst_bus_sched : FT600 245-sync bus scheduler, RX/TX with turnaround |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mst_bus_sched #(
  parameter int MAX_BURST = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rxf_n,
  input  logic txe_n,
  input  logic r_oob,
  input  logic w_oob,
  input  logic rx_ready,
  input  logic tx_avail,
  output logic oe_n,
  output logic rd_n,
  output logic wr_n,
  output logic dt_oe_n,
  output logic be_oe_n,
  output logic rx_vld,
  output logic tx_pop,
  output logic dir,
  output logic busy
);
  import mst_fifo_pkg::*;

  localparam int            CW       = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TA_W-1:0] ta_q, ta_d;
  logic            oe_n_q, rd_n_q, wr_n_q, dt_oe_n_q, be_oe_n_q;

  logic rx_req, tx_req;
  logic gnt_rx, gnt_tx;
  logic ta_done;
  logic rx_own_d, tx_own_d;

  assign rx_req  = ~rxf_n & rx_ready & ~r_oob;
  assign tx_req  = ~txe_n & tx_avail & ~w_oob;
  assign ta_done = (ta_q == TA_W'(TA_CYC - 1));

  mst_rr_pick u_rr_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (state_q == ST_IDLE),
    .req_rx_i (rx_req),
    .req_tx_i (tx_req),
    .gnt_rx_o (gnt_rx),
    .gnt_tx_o (gnt_tx),
    .last_o   (dir)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ta_d    = '0;
    rx_vld  = (state_q == ST_RX_RD) & ~rxf_n;
    tx_pop  = (state_q == ST_TX_WR) & ~txe_n;
    case (state_q)
      ST_IDLE: begin
        if (gnt_rx) begin
          state_d = ST_RX_OE;
          cnt_d   = '0;
        end else if (gnt_tx) begin
          state_d = ST_TX_DRV;
          cnt_d   = '0;
        end
      end
      ST_RX_OE: state_d = ST_RX_RD;
      ST_RX_RD: begin
        if (rx_vld) cnt_d = cnt_q + 1'b1;
        // Exit is decided on this cycle's inputs; the sink's 2-word margin
        // absorbs the one strobe already committed.
        if (rxf_n || !rx_ready || r_oob || (rx_vld && (cnt_q == CNT_LAST)))
          state_d = ST_RX_END;
      end
      ST_RX_END: begin
        if (ta_done) state_d = ST_IDLE;
        else         ta_d    = ta_q + 1'b1;
      end
      ST_TX_DRV: state_d = ST_TX_WR;
      ST_TX_WR: begin
        if (tx_pop) cnt_d = cnt_q + 1'b1;
        if (txe_n || !tx_avail || w_oob || (tx_pop && (cnt_q == CNT_LAST)))
          state_d = ST_TX_END;
      end
      ST_TX_END: begin
        if (ta_done) state_d = ST_IDLE;
        else         ta_d    = ta_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pad controls are registered from the next state so they are glitch-free
  // and line up with the state they belong to.
  assign rx_own_d = (state_d == ST_RX_OE) || (state_d == ST_RX_RD);
  assign tx_own_d = (state_d == ST_TX_DRV) || (state_d == ST_TX_WR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ta_q      <= '0;
      oe_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      dt_oe_n_q <= 1'b1;
      be_oe_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ta_q      <= ta_d;
      oe_n_q    <= ~rx_own_d;
      rd_n_q    <= ~(state_d == ST_RX_RD);
      wr_n_q    <= ~(state_d == ST_TX_WR);
      dt_oe_n_q <= ~tx_own_d;
      be_oe_n_q <= ~tx_own_d;
    end
  end

  assign oe_n    = oe_n_q;
  assign rd_n    = rd_n_q;
  assign wr_n    = wr_n_q;
  assign dt_oe_n = dt_oe_n_q;
  assign be_oe_n = be_oe_n_q;
  assign busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mst_bus_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mst_bus_sched : scenario bench, two instances (long / capped)    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_mst_bus_sched;

  localparam int NDUT = 2;
  localparam int MB_A = 256;
  localparam int MB_B = 4;
  localparam int MIDLE = 0, MRX = 1, MTX = 2;
  localparam int PSETUP = 0, PDATA = 1, PTURN = 2;
  localparam logic [8:0] RST_VEC = 9'b1_1_1_1_1_0_0_1_0;

  typedef struct packed {
    int mode;
    int phase;
    int beats;
    bit last;
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rxf_n = 1'b1, txe_n = 1'b1, r_oob = 1'b0, w_oob = 1'b0;
  logic rx_ready = 1'b0, tx_avail = 1'b0;
  logic [NDUT-1:0] oe_n, rd_n, wr_n, dt_oe_n, be_oe_n, rx_vld, tx_pop, dir, busy;

  int errors = 0;
  int checks = 0;
  mdl_t m [NDUT];
  int cap [NDUT] = '{MB_A, MB_B};

  always #5 clk = ~clk;

  mst_bus_sched #(.MAX_BURST(MB_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .rxf_n(rxf_n), .txe_n(txe_n), .r_oob(r_oob), .w_oob(w_oob),
    .rx_ready(rx_ready), .tx_avail(tx_avail), .oe_n(oe_n[0]), .rd_n(rd_n[0]), .wr_n(wr_n[0]),
    .dt_oe_n(dt_oe_n[0]), .be_oe_n(be_oe_n[0]), .rx_vld(rx_vld[0]), .tx_pop(tx_pop[0]),
    .dir(dir[0]), .busy(busy[0])
  );

  mst_bus_sched #(.MAX_BURST(MB_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .rxf_n(rxf_n), .txe_n(txe_n), .r_oob(r_oob), .w_oob(w_oob),
    .rx_ready(rx_ready), .tx_avail(tx_avail), .oe_n(oe_n[1]), .rd_n(rd_n[1]), .wr_n(wr_n[1]),
    .dt_oe_n(dt_oe_n[1]), .be_oe_n(be_oe_n[1]), .rx_vld(rx_vld[1]), .tx_pop(tx_pop[1]),
    .dir(dir[1]), .busy(busy[1])
  );

  // Reference: an instance is idle or owns one direction; an owned burst is
  // a setup cycle, a data phase, and a turnaround cycle.
  function automatic mdl_t next_m(input mdl_t s, input int cap_k);
    mdl_t n;
    bit rq, tq, beat, stop;
    n  = s;
    rq = !rxf_n && rx_ready && !r_oob;
    tq = !txe_n && tx_avail && !w_oob;
    if (s.mode == MIDLE) begin
      if (rq && (!tq || s.last)) n = '{MRX, PSETUP, 0, 1'b0};
      else if (tq)               n = '{MTX, PSETUP, 0, 1'b1};
    end else if (s.phase == PSETUP) begin
      n.phase = PDATA;
    end else if (s.phase == PDATA) begin
      beat    = (s.mode == MRX) ? !rxf_n : !txe_n;
      n.beats = s.beats + int'(beat);
      stop    = (s.mode == MRX) ? (rxf_n || !rx_ready || r_oob)
                                : (txe_n || !tx_avail || w_oob);
      if (stop || (beat && n.beats == cap_k)) n.phase = PTURN;
    end else begin
      n.mode = MIDLE;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NDUT; k++) begin
      if (!rst_n) m[k] <= '{MIDLE, PSETUP, 0, 1'b1};
      else        m[k] <= next_m(m[k], cap[k]);
    end
  end

  // {oe_n, rd_n, wr_n, dt_oe_n, be_oe_n, rx_vld, tx_pop, dir, busy}
  function automatic logic [8:0] exp_vec(input int k);
    mdl_t s;
    logic rx_on, tx_on, rx_dat, tx_dat;
    s      = m[k];
    rx_on  = (s.mode == MRX) && (s.phase != PTURN);
    tx_on  = (s.mode == MTX) && (s.phase != PTURN);
    rx_dat = (s.mode == MRX) && (s.phase == PDATA);
    tx_dat = (s.mode == MTX) && (s.phase == PDATA);
    return {~rx_on, ~rx_dat, ~tx_dat, ~tx_on, ~tx_on,
            rx_dat && !rxf_n, tx_dat && !txe_n, s.last, s.mode != MIDLE};
  endfunction

  function automatic logic [8:0] obs_vec(input int k);
    return {oe_n[k], rd_n[k], wr_n[k], dt_oe_n[k], be_oe_n[k],
            rx_vld[k], tx_pop[k], dir[k], busy[k]};
  endfunction

  task automatic set_in(input logic rf, input logic te, input logic ro, input logic wo,
                        input logic rr, input logic ta);
    rxf_n = rf; txe_n = te; r_oob = ro; w_oob = wo; rx_ready = rr; tx_avail = ta;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_in(1, 1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    set_in(0, 0, 0, 0, 1, 1);
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (obs_vec(k) !== RST_VEC) begin
        errors++;
        $display("FAIL reset dut%0d got=%b want=%b", k, obs_vec(k), RST_VEC);
      end
    end
    @(negedge clk);
    set_in(1, 1, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic test_rx_only();
    int nvld = 0, after = -1;
    bit seen_oe = 1'b0;
    do_reset();
    set_in(0, 1, 0, 0, 1, 0);
    for (int c = 0; c < 60 && after < 4; c++) begin
      @(negedge clk);
      if (nvld == 10 && after < 0) begin rxf_n = 1'b1; after = 0; end
      #1;
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL rx_only dut%0d t=%0t got=%b want=%b", k, $time, obs_vec(k), exp_vec(k));
        end
      end
      if (!oe_n[0] && !seen_oe) begin
        seen_oe = 1'b1;
        checks++;
        if (rd_n[0] !== 1'b1) begin
          errors++;
          $display("FAIL rx_oe_lead got rd_n=%b want 1 on first oe_n low", rd_n[0]);
        end
      end
      if (rx_vld[0]) nvld++;
      if (after >= 0) begin
        if (after == 2) begin
          checks++;
          if (busy[0] !== 1'b0 || oe_n[0] !== 1'b1) begin
            errors++;
            $display("FAIL rx_release got busy=%b oe_n=%b want busy=0 oe_n=1", busy[0], oe_n[0]);
          end
        end
        after++;
      end
    end
    checks++;
    if (nvld !== 10) begin
      errors++;
      $display("FAIL rx_count got=%0d want=10", nvld);
    end
  endtask

  task automatic test_burst_cap();
    int run = 0, gap = 0, nruns = 0;
    bit prev = 1'b0;
    do_reset();
    set_in(1, 0, 0, 0, 0, 1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 34) txe_n = 1'b1;
      #1;
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL burst_cap dut%0d t=%0t got=%b want=%b", k, $time, obs_vec(k), exp_vec(k));
        end
      end
      if (tx_pop[1]) begin
        if (!prev && gap >= 1) begin
          checks++;
          if (gap !== 3) begin
            errors++;
            $display("FAIL burst_gap got=%0d want=3", gap);
          end
        end
        run++;
      end else begin
        if (prev) begin
          if (!txe_n) begin
            checks++;
            nruns++;
            if (run !== MB_B) begin
              errors++;
              $display("FAIL burst_len got=%0d want=%0d", run, MB_B);
            end
          end
          run = 0;
          gap = 1;
        end else if (gap >= 1) begin
          gap++;
        end
      end
      prev = tx_pop[1];
    end
    checks++;
    if (nruns < 3) begin
      errors++;
      $display("FAIL burst_runs got=%0d want>=3", nruns);
    end
  endtask

  task automatic test_alternate();
    int ng = 0;
    logic [2:0] gd = 3'b000;
    bit pb = 1'b0;
    do_reset();
    set_in(0, 0, 0, 0, 1, 1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k) || (!oe_n[k] && !dt_oe_n[k])) begin
          errors++;
          $display("FAIL alternate dut%0d t=%0t got=%b want=%b", k, $time, obs_vec(k), exp_vec(k));
        end
      end
      if (busy[1] && !pb && ng < 3) begin gd[ng] = dir[1]; ng++; end
      pb = busy[1];
    end
    checks++;
    if (ng !== 3 || gd !== 3'b010) begin
      errors++;
      $display("FAIL grant_order got n=%0d dirs(2..0)=%b want n=3 dirs=010", ng, gd);
    end
  endtask

  task automatic test_r_oob();
    int nvld = 0, extra = 0, raised = -1;
    bit tx_seen = 1'b0;
    do_reset();
    set_in(0, 0, 0, 0, 1, 1);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (nvld == 2 && raised < 0 && !rd_n[0]) begin r_oob = 1'b1; raised = c; end
      #1;
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL r_oob dut%0d t=%0t got=%b want=%b", k, $time, obs_vec(k), exp_vec(k));
        end
      end
      if (raised < 0 || c == raised) begin
        if (rx_vld[0]) nvld++;
      end else begin
        if (rx_vld[0]) extra++;
        if (tx_pop[0]) tx_seen = 1'b1;
        checks++;
        if (oe_n[0] !== 1'b1) begin
          errors++;
          $display("FAIL oob_hold t=%0t got oe_n=%b want 1", $time, oe_n[0]);
        end
      end
    end
    checks++;
    if (raised < 0 || nvld !== 3 || extra > 1 || !tx_seen) begin
      errors++;
      $display("FAIL oob_summary got raised=%0d beats=%0d extra=%0d tx=%0d want beats=3 extra<=1 tx=1",
               raised, nvld, extra, tx_seen);
    end
  endtask

  task automatic test_rx_ready_drop();
    int k0, hold;
    int nvld = 0, drop = -1, extra = 0, resumed = 0;
    k0   = $urandom_range(2, 6);
    hold = $urandom_range(3, 8);
    do_reset();
    set_in(0, 1, 0, 0, 1, 0);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (nvld == k0 && drop < 0) begin rx_ready = 1'b0; drop = c; end
      if (drop >= 0 && c == drop + hold) rx_ready = 1'b1;
      #1;
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL rdy_drop dut%0d t=%0t got=%b want=%b", k, $time, obs_vec(k), exp_vec(k));
        end
      end
      if (drop < 0) begin
        if (rx_vld[0]) nvld++;
      end else if (c < drop + hold) begin
        if (rx_vld[0]) extra++;
        if (c >= drop + 1) begin
          checks++;
          if (oe_n[0] !== 1'b1) begin
            errors++;
            $display("FAIL rdy_hold t=%0t got oe_n=%b want 1", $time, oe_n[0]);
          end
        end
      end else if (rx_vld[0]) begin
        resumed++;
      end
    end
    checks++;
    if (drop < 0 || extra > 1 || resumed == 0) begin
      errors++;
      $display("FAIL rdy_summary got drop=%0d extra=%0d resumed=%0d want extra<=1 resumed>0",
               drop, extra, resumed);
    end
  endtask

  task automatic test_reset_mid_tx();
    int seen = -1;
    logic [NDUT-1:0] fd = '1;
    logic [NDUT-1:0] got = '0;
    do_reset();
    set_in(1, 0, 0, 0, 0, 1);
    for (int c = 0; c < 20 && seen < 0; c++) begin
      @(negedge clk);
      #1;
      if (tx_pop[0]) seen = c;
    end
    checks++;
    if (seen < 0) begin
      errors++;
      $display("FAIL mid_tx_timeout got no tx_pop within 20 cycles");
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (obs_vec(k) !== RST_VEC || {wr_n[k], dt_oe_n[k], be_oe_n[k]} !== 3'b111) begin
        errors++;
        $display("FAIL async_reset dut%0d got=%b want=%b", k, obs_vec(k), RST_VEC);
      end
    end
    @(negedge clk);
    set_in(0, 0, 0, 0, 1, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL post_reset dut%0d t=%0t got=%b want=%b", k, $time, obs_vec(k), exp_vec(k));
        end
        if (busy[k] && !got[k]) begin got[k] = 1'b1; fd[k] = dir[k]; end
      end
    end
    checks++;
    if (got !== 2'b11 || fd !== 2'b00) begin
      errors++;
      $display("FAIL first_tie got granted=%b dir=%b want granted=11 dir=00", got, fd);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rxf_n    = ($urandom_range(0, 3) == 0);
      txe_n    = ($urandom_range(0, 3) == 0);
      r_oob    = ($urandom_range(0, 11) == 0);
      w_oob    = ($urandom_range(0, 11) == 0);
      rx_ready = ($urandom_range(0, 7) != 0);
      tx_avail = ($urandom_range(0, 7) != 0);
      #1;
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL random dut%0d t=%0t got=%b want=%b", k, $time, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rx_only();
    test_burst_cap();
    test_alternate();
    test_r_oob();
    test_rx_ready_drop();
    test_reset_mid_tx();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mst_bus_sched.md
Name: mst_bus_sched

Overview:
- Schedules the shared FT600 245-sync FIFO bus between the receive direction (FT600 -> FPGA, RXF_N) and the transmit direction (FPGA -> FT600, TXE_N).
- Sits between the pads and the datapath. It drives OE_N, RD_N, WR_N and the DATA/BE output enables; it strobes the checker-side sink and the prefetch-side source.
- Enforces round-robin fairness, a maximum burst length, out-of-band holds and one-cycle bus turnaround.

Parameters:
MAX_BURST, 256, maximum data beats per burst before the bus is released (1..4096)

Ports:
clk  in  1  FT600 bus clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
rxf_n  in  1  FT600 receive data available (low = word available)
txe_n  in  1  FT600 transmit space available (low = space)
r_oob  in  1  hold receive direction: no new RX burst; an active RX burst ends
w_oob  in  1  hold transmit direction: no new TX burst; an active TX burst ends
rx_ready  in  1  sink has space for at least 2 more words
tx_avail  in  1  source has at least 2 words ready
oe_n  out  1  FT600 output enable
rd_n  out  1  FT600 read strobe
wr_n  out  1  FT600 write strobe
dt_oe_n  out  1  FPGA drive enable, DATA[15:8]
be_oe_n  out  1  FPGA drive enable, DATA[7:0] and BE
rx_vld  out  1  DATA/BE hold a valid received word this cycle (combinational)
tx_pop  out  1  current tx word consumed; source advances (combinational)
dir  out  1  last granted direction: 0 = RX, 1 = TX
busy  out  1  state is not IDLE

Behaviour:
Reset:
- States: IDLE, RX_OE, RX_RD, RX_END, TX_DRV, TX_WR, TX_END.
- On reset: state = IDLE; oe_n, rd_n, wr_n, dt_oe_n, be_oe_n = 1; dir = 1, so RX wins the first tie; beat counter = 0.
- Reset assertion mid-burst drops all strobes and drivers asynchronously.

Outputs and strobes:
- oe_n, rd_n, wr_n, dt_oe_n and be_oe_n are registered, decoded from the next state.
- rx_vld = (state==RX_RD) & ~rxf_n.
- tx_pop = (state==TX_WR) & ~txe_n.

Requests and arbitration (in IDLE):
- rx_req = ~rxf_n & rx_ready & ~r_oob.
- tx_req = ~txe_n & tx_avail & ~w_oob.
- Only one request active -> grant it.
- Both active -> grant the direction opposite to dir.
- On a grant: dir updates and the beat counter clears.
- RX grant -> RX_OE. TX grant -> TX_DRV.

RX sequence:
- RX_OE: 1 cycle, oe_n = 0, rd_n = 1. The FT600 takes the bus.
- RX_RD: oe_n = 0, rd_n = 0. Counter increments on each rx_vld.
- Exit RX_RD -> RX_END when any of these holds:
  - rxf_n = 1
  - rx_vld with counter == MAX_BURST-1
  - rx_ready = 0
  - r_oob = 1
- RX_END: 1 cycle, oe_n = rd_n = 1 (turnaround), then IDLE.

TX sequence:
- TX_DRV: 1 cycle, dt_oe_n = be_oe_n = 0, wr_n = 1. The FPGA takes the bus.
- TX_WR: wr_n = 0, drivers stay on. Counter increments on each tx_pop.
- Exit TX_WR -> TX_END when any of these holds:
  - txe_n = 1
  - tx_pop with counter == MAX_BURST-1
  - tx_avail = 0
  - w_oob = 1
- TX_END: 1 cycle, wr_n = 1, drivers off, then IDLE.

Boundary rules:
- Exit is decided from the current cycle, so one extra strobed cycle may transfer one more word. This is why rx_ready and tx_avail guarantee 2 words.
- No beat ever transfers with both drivers on and oe_n = 0.
- Minimum gap between opposite-direction bursts is END + IDLE = 2 cycles.
- A rxf_n high glitch ends the burst; no word is counted for that cycle.
- MAX_BURST = 1 gives single-beat bursts.
- Counter width = $clog2(MAX_BURST+1). No wrap; the counter is cleared on every grant.

Decomposition:
- Shared package mst_fifo_pkg holds:
  - state enum encoding
  - DIR_RX / DIR_TX constants
  - TA_CYC = 1 turnaround constant, used by mst_fifo_fsm checks as well
- One natural sub-module: mst_rr_pick, a 2-requester round-robin picker with a last-grant register.

Test Plan:
1. RX only: rxf_n low for 10 words, rx_ready = 1, MAX_BURST = 256.
   -> oe_n falls 1 cycle before rd_n; exactly 10 rx_vld; RX_END; oe_n high; busy low 2 cycles after rxf_n rises.
2. TX burst cap: txe_n low, tx_avail = 1, MAX_BURST = 4.
   -> repeating pattern of 4 tx_pop, TX_END, IDLE, TX_DRV, 4 tx_pop; dt_oe_n = 0 only in TX_DRV/TX_WR.
3. Both requests persistent, from reset.
   -> grants alternate RX, TX, RX; dir toggles 0, 1, 0; oe_n and dt_oe_n never both 0.
4. r_oob raised on the 3rd RX beat.
   -> at most 1 further rx_vld, then RX_END; no RX grant while r_oob = 1; TX still served.
5. rx_ready drops mid-burst.
   -> ≤ 1 extra rx_vld, burst ends; resumes when rx_ready returns with rxf_n low.
6. rst_n asserted during TX_WR.
   -> wr_n, dt_oe_n, be_oe_n = 1 immediately; after release, IDLE and the first tie goes to RX.
